player_sprite_gen: RTL

PLAYER_SPRITE_GEN -- requirements
Module: player_sprite_gen

---
 rtl/player_sprite_gen.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/player_sprite_gen.sv
// Player sprite generator: tile-based movement FSM with smooth per-frame
// pixel offset, plus a 2-stage pixel pipeline that addresses the sprite ROM
// and emits the player layer pixel (12'hCBE = transparent).
//
// Handshake: a movement request is a transfer when move_valid && move_ready
// are both high on a rising clock edge. move_ready is high exactly while the
// FSM is IDLE. A transfer with move_blocked low and an in-bounds target
// starts a move; any other transfer only turns the player to face move_dir.
// move_valid while not ready is ignored and has no effect.
module player_sprite_gen #(
  parameter int START_X = 1,
  parameter int START_Y = 1,
  parameter int STEP    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        vga_valid,
  input  logic        frame_tick,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  input  logic        move_blocked,
  output logic        move_ready,
  output logic [4:0]  tile_x,
  output logic [3:0]  tile_y,
  output logic [12:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] pixel_player,
  output logic        state_dbg
);

  localparam logic [4:0]  START_TX    = 5'(START_X);
  localparam logic [3:0]  START_TY    = 4'(START_Y);
  localparam logic [5:0]  STEP_W      = 6'(STEP);
  localparam logic [4:0]  MAX_TX      = 5'd19;
  localparam logic [3:0]  MAX_TY      = 4'd14;
  localparam logic [11:0] TRANSPARENT = 12'hCBE;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } state_t;

  state_t      state_q;
  logic [4:0]  tile_x_q;
  logic [3:0]  tile_y_q;
  logic [4:0]  off_q;
  logic [1:0]  facing_q;

  logic        hit_q;
  logic [12:0] rom_addr_q;
  logic [11:0] pixel_q;

  // Movement helpers
  logic        target_ok;
  logic [5:0]  off_sum;
  logic        anim;

  // Draw position and pipeline stage-1 next values
  logic [9:0]  base_x;
  logic [9:0]  base_y;
  logic [9:0]  off_ext;
  logic [9:0]  px;
  logic [9:0]  py;
  logic        hit_d;
  logic [4:0]  sx_d;
  logic [4:0]  sy_d;
  logic [12:0] rom_addr_d;
  logic [11:0] pixel_d;

  // Target-tile bounds check for the requested direction
  always_comb begin
    target_ok = 1'b0;
    case (move_dir)
      DIR_UP:    target_ok = (tile_y_q != 4'd0);
      DIR_DOWN:  target_ok = (tile_y_q < MAX_TY);
      DIR_LEFT:  target_ok = (tile_x_q != 5'd0);
      DIR_RIGHT: target_ok = (tile_x_q < MAX_TX);
      default:   target_ok = 1'b0;
    endcase
  end

  assign off_sum = {1'b0, off_q} + STEP_W;
  assign anim    = off_q[3];

  // Movement FSM: accepts requests in IDLE, walks one tile in STEP increments
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      tile_x_q <= START_TX;
      tile_y_q <= START_TY;
      off_q    <= 5'd0;
      facing_q <= DIR_DOWN;
    end else begin
      case (state_q)
        IDLE: begin
          if (move_valid) begin
            facing_q <= move_dir;
            if (!move_blocked && target_ok) begin
              // A coincident frame_tick does not advance: first step comes
              // on the next tick, so off stays 0 here.
              state_q <= MOVING;
              off_q   <= 5'd0;
            end
          end
        end
        MOVING: begin
          if (frame_tick) begin
            if (off_sum < 6'd32) begin
              off_q <= off_sum[4:0];
            end else begin
              // Tile commit and offset clear land on the same tick so the
              // draw position never jumps within a frame.
              case (facing_q)
                DIR_UP:    tile_y_q <= tile_y_q - 4'd1;
                DIR_DOWN:  tile_y_q <= tile_y_q + 4'd1;
                DIR_LEFT:  tile_x_q <= tile_x_q - 5'd1;
                default:   tile_x_q <= tile_x_q + 5'd1;
              endcase
              off_q   <= 5'd0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Draw position: tile origin shifted by the walk offset along facing
  always_comb begin
    base_x  = {tile_x_q, 5'd0};
    base_y  = {1'b0, tile_y_q, 5'd0};
    off_ext = {5'd0, off_q};
    px      = base_x;
    py      = base_y;
    case (facing_q)
      DIR_UP:    py = base_y - off_ext;
      DIR_DOWN:  py = base_y + off_ext;
      DIR_LEFT:  px = base_x - off_ext;
      default:   px = base_x + off_ext;
    endcase
  end

  // Stage-1 hit test and sprite-local coordinates; low 5 bits of the
  // difference are taken directly since the box is exactly 32 px wide.
  always_comb begin
    hit_d = vga_valid &&
            (h_cnt >= px) && (h_cnt < px + 10'd32) &&
            (v_cnt >= py) && (v_cnt < py + 10'd32);
    sx_d  = h_cnt[4:0] - px[4:0];
    sy_d  = v_cnt[4:0] - py[4:0];
    rom_addr_d = rom_addr_q;
    if (hit_d) begin
      rom_addr_d = {facing_q, anim, sy_d, sx_d};
    end
  end

  // Stage 1: register ROM address (held on miss) and hit flag
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q      <= 1'b0;
      rom_addr_q <= 13'd0;
    end else begin
      hit_q      <= hit_d;
      rom_addr_q <= rom_addr_d;
    end
  end

  // Stage-2 select: ROM pixel on a hit, transparent otherwise
  always_comb begin
    pixel_d = TRANSPARENT;
    if (hit_q) begin
      pixel_d = rom_data;
    end
  end

  // Stage 2: register the player layer pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_q <= TRANSPARENT;
    end else begin
      pixel_q <= pixel_d;
    end
  end

  assign move_ready   = (state_q == IDLE);
  assign tile_x       = tile_x_q;
  assign tile_y       = tile_y_q;
  assign rom_addr     = rom_addr_q;
  assign pixel_player = pixel_q;
  assign state_dbg    = state_q;

endmodule
